// File: rtl/datapath_exp1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_exp1_pkg
// Description : Shared types and constants for the datapath_exp1 slice:
//               FSM state enumeration, op_code encodings and data width.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_exp1_pkg;

  // Default data path width used by the top level
  localparam int WIDTH = 16;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    FIN    = 2'd3
  } state_e;

  // Operation select encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage : datapath_exp1_pkg
`default_nettype wire

// File: rtl/datapath_exp1_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : control_path_exp1
// Description : Four-state sequencer (IDLE -> LOAD_B -> EXEC -> FIN) that
//               issues the operand/result load strobes and the finish pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module control_path_exp1
  import datapath_exp1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ldA,
  output logic ldB,
  output logic ldO,
  output logic finish
);

  state_e state_q;

  // State register: start is only honoured in IDLE, the rest is a fixed walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= LOAD_B;
        LOAD_B:  state_q <= EXEC;
        EXEC:    state_q <= FIN;
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe decode: one-hot by construction since each depends on one state
  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    ldO    = 1'b0;
    finish = 1'b0;
    case (state_q)
      IDLE:    ldA    = start;
      LOAD_B:  ldB    = 1'b1;
      EXEC:    ldO    = 1'b1;
      FIN:     finish = 1'b1;
      default: ;
    endcase
  end

endmodule : control_path_exp1
`default_nettype wire

// File: rtl/datapath_exp1.sv
`default_nettype none
// ============================================================================
// Module      : datapath_exp1
// Description : Two-operand ALU datapath. Operand A and the op_code are
//               captured on start, operand B one cycle later, and the
//               result is registered the cycle after that.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_exp1 #(
  parameter int WIDTH = datapath_exp1_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       op_code,
  output logic             ldA,
  output logic             ldB,
  output logic             ldO,
  output logic             finish,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  import datapath_exp1_pkg::OP_ADD;
  import datapath_exp1_pkg::OP_SUB;
  import datapath_exp1_pkg::OP_AND;
  import datapath_exp1_pkg::OP_OR;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             done_q;

  control_path_exp1 u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ldA    (ldA),
    .ldB    (ldB),
    .ldO    (ldO),
    .finish (finish)
  );

  // ALU: add/sub wrap naturally at WIDTH bits, no carry/borrow kept
  always_comb begin
    result_d = '0;
    case (op_q)
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      default: result_d = '0;
    endcase
  end

  // Operand, op and result registers loaded only on their strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else begin
      if (ldA) begin
        a_q  <= d_in;
        op_q <= op_code;
      end
      if (ldB) begin
        b_q <= d_in;
      end
      if (ldO) begin
        result_q <= result_d;
      end
    end
  end

  // Result-valid flag: dropped when a new operation is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (ldA) begin
      done_q <= 1'b0;
    end else if (ldO) begin
      done_q <= 1'b1;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule : datapath_exp1
`default_nettype wire

// File: tb/tb_datapath_exp1.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_exp1
// Description : Self-checking bench for datapath_exp1: directed vector table,
//               randomized operations against a transaction-level model,
//               mid-operation disturbance, reset abort and back-to-back runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_exp1;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] d_in;
  logic [1:0]   op_code;
  logic         ldA;
  logic         ldB;
  logic         ldO;
  logic         finish;
  logic         done;
  logic [W-1:0] result;

  int checks;
  int failures;
  logic exp_done;

  datapath_exp1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .d_in    (d_in),
    .op_code (op_code),
    .ldA     (ldA),
    .ldB     (ldB),
    .ldO     (ldO),
    .finish  (finish),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  // Transaction-level reference: plain integer arithmetic modulo 2^16
  function automatic logic [W-1:0] model(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 65536;
      1:       r = (a - b + 65536) % 65536;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes packed as {ldA, ldB, ldO, finish}
  function automatic logic [3:0] strobes();
    return {ldA, ldB, ldO, finish};
  endfunction

  // One full operation, 4 cycles, starting in IDLE just after a rising edge.
  // hold_start keeps start high throughout (back-to-back launches).
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] exp, input bit hold_start);
    // Cycle 1: IDLE, present A and op
    start = 1'b1; d_in = a; op_code = op;
    @(negedge clk);
    check({name, " c1 strobes"}, 32'(strobes()), 32'(4'b1000));
    check({name, " c1 done"}, 32'(done), 32'(exp_done));
    @(posedge clk); #1;
    exp_done = 1'b0;
    // Cycle 2: LOAD_B, present B; start noise must be ignored
    start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
    d_in = b; op_code = 2'($urandom);
    @(negedge clk);
    check({name, " c2 strobes"}, 32'(strobes()), 32'(4'b0100));
    check({name, " c2 done"}, 32'(done), 32'(0));
    @(posedge clk); #1;
    // Cycle 3: EXEC, scramble the data inputs
    start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
    d_in = W'($urandom); op_code = 2'($urandom);
    @(negedge clk);
    check({name, " c3 strobes"}, 32'(strobes()), 32'(4'b0010));
    @(posedge clk); #1;
    exp_done = 1'b1;
    // Cycle 4: FIN
    start = hold_start;
    d_in = W'($urandom); op_code = 2'($urandom);
    @(negedge clk);
    check({name, " c4 strobes"}, 32'(strobes()), 32'(4'b0001));
    check({name, " c4 done"}, 32'(done), 32'(1));
    check({name, " result"}, 32'(result), 32'(exp));
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic [W-1:0] last_res;

    checks   = 0;
    failures = 0;
    exp_done = 1'b0;

    vecs[0] = '{a: 16'd3,      b: 16'd1, op: 2'b00, exp: 16'd4};
    vecs[1] = '{a: 16'd3,      b: 16'd1, op: 2'b01, exp: 16'd2};
    vecs[2] = '{a: 16'd3,      b: 16'd1, op: 2'b10, exp: 16'd1};
    vecs[3] = '{a: 16'd3,      b: 16'd1, op: 2'b11, exp: 16'd3};
    vecs[4] = '{a: 16'hFFFF,   b: 16'd1, op: 2'b00, exp: 16'h0000};
    vecs[5] = '{a: 16'h0000,   b: 16'd1, op: 2'b01, exp: 16'hFFFF};

    // Reset state
    rst = 1'b1; start = 1'b0; d_in = '0; op_code = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset strobes", 32'(strobes()), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset result", 32'(result), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0);
    end

    // Idle hold: done and result stay put without a start
    last_res = vecs[5].exp;
    repeat (3) begin
      @(negedge clk);
      check("idle hold done", 32'(done), 32'(1));
      check("idle hold result", 32'(result), 32'(last_res));
      check("idle strobes", 32'(strobes()), 32'(0));
      @(posedge clk); #1;
    end

    // Randomized operations against the model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      if (i % 5 == 0) ra = 16'hFFFF;
      if (i % 7 == 0) rb = 16'hFFFF;
      run_op($sformatf("rand%0d", i), ra, rb, rop, model(int'(ra), int'(rb), int'(rop)), 1'b0);
    end

    // Reset asserted in EXEC aborts immediately
    start = 1'b1; d_in = 16'd9; op_code = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; d_in = 16'd4;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-abort in EXEC", 32'(strobes()), 32'(4'b0010));
    #1 rst = 1'b1;
    #1;
    check("abort strobes", 32'(strobes()), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort result", 32'(result), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = 1'b0;
    @(negedge clk);
    check("post-abort idle", 32'(strobes()), 32'(0));
    @(posedge clk); #1;
    run_op("after reset", 16'd5, 16'd2, 2'b01, 16'd3, 1'b0);

    // Back-to-back with start held high
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      run_op($sformatf("b2b%0d", i), ra, rb, rop, model(int'(ra), int'(rb), int'(rop)), 1'b1);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_datapath_exp1
`default_nettype wire

// File: doc/datapath_exp1.md
DATAPATH_EXP1 -- requirements
Module: datapath_exp1

Interface
REQ-001 The block SHALL have these parameters, one per line: WIDTH, default 16, data path width; none other.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request to begin one operation
- d_in  input  16  operand bus
- op_code  input  2  operation select
- ldA  output  1  operand A load strobe
- ldB  output  1  operand B load strobe
- ldO  output  1  result load strobe
- finish  output  1  one-cycle completion pulse
- done  output  1  result-valid flag
- result  output  16  operation result
REQ-003 The block SHALL use one clock. Reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have four states:
- IDLE
- LOAD_B
- EXEC
- FIN
REQ-005 In IDLE, ldA SHALL equal start. On a rising edge with start=1:
- A <= d_in
- OP <= op_code
- next state = LOAD_B
REQ-006 In LOAD_B, ldB SHALL be 1. On the next edge:
- B <= d_in
- next state = EXEC
REQ-007 In EXEC, ldO SHALL be 1. On the next edge:
- result <= f(A,B,OP)
- next state = FIN
REQ-008 In FIN, finish SHALL be 1. On the next edge the FSM SHALL return to IDLE.
REQ-009 Operations SHALL be:
- 00 = A+B
- 01 = A-B
- 10 = A AND B
- 11 = A OR B
REQ-010 Add and subtract SHALL wrap modulo 2^16, with no carry or borrow output.
REQ-011 ldA, ldB, ldO and finish SHALL be combinational decodes of state (and of start in IDLE), mutually exclusive.
REQ-012 done SHALL be a register:
- set on the edge where result is loaded
- cleared on the edge where a new start is accepted
- otherwise held
REQ-013 The start-to-finish latency SHALL be 3 cycles, with finish high in the 4th cycle.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 d_in and op_code SHALL be ignored except at the sampling edges in REQ-005 and REQ-006.
REQ-016 start held high continuously SHALL launch a new operation on the first edge after FIN, giving back-to-back operations every 4 cycles.
REQ-017 result SHALL hold its value until the next EXEC.

Reset
REQ-018 While rst=1:
- state = IDLE
- A, B and result = 0
- OP = 00
- done = 0
- ldB, ldO and finish = 0
REQ-019 Reset asserted mid-operation SHALL abort the operation immediately. The first start after rst deasserts SHALL begin a fresh operation.

Structure
REQ-020 A shared package SHALL hold:
- the state enumeration
- the op_code constants (OP_ADD, OP_SUB, OP_AND, OP_OR)
- WIDTH
REQ-021 The FSM SHALL be a sub-module control_path_exp1 with these ports:
- inputs: clk, rst, start
- outputs: ldA, ldB, ldO, finish
REQ-022 Registers A, B, OP and result, the ALU and done SHALL reside in the top level.

Verification
REQ-023 Add: start=1 with d_in=3 and op=00, next cycle d_in=1 -> ldA, ldB and ldO each pulse once in order; result=4, done=1 and finish pulses in cycle 4.
REQ-024 Subtract and logic, each with A=3, B=1:
- op=01 -> result=2
- op=10 -> result=1
- op=11 -> result=3
REQ-025 Wrap-around:
- A=0xFFFF, B=1, op=00 -> result=0x0000
- A=0, B=1, op=01 -> result=0xFFFF
REQ-026 Mid-operation changes: start pulsed during LOAD_B/EXEC, and d_in/op_code changed during EXEC -> no effect; the original result is produced.
REQ-027 Reset: rst asserted in EXEC -> immediate return to IDLE with all outputs 0. The next start with A=5, B=2, op=01 -> result=3.
REQ-028 Back-to-back: start held high -> operations launch every 4 cycles; done drops on each accepted start and rises after each EXEC.
